sram_1r1w_bypass_ext: RTL and testbench

Parametrised single-clock 1-read/1-write SRAM macro model for array wrappers that need sub-word write masks, selectable read latency and deterministic read-during-write behaviour. Reads are captured into an output pipeline, so data stays stable until the next completed read and later writes do not disturb it. The block sits under the cache and predictor array wrappers and replaces the per-instance unmasked, dual-clock models for arrays on a single clock domain.

---
 rtl/sram_1r1w_bypass_ext.sv | 68 ++++++
 tb/tb_sram_1r1w_bypass_ext.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_bypass_ext.sv
// sram_1r1w_bypass_ext: single-clock 1R1W SRAM model with lane write masks, 1/2-cycle read latency and collision bypass
//   clock, reset       : shared clock, synchronous active-high reset
//   R0_en, R0_addr     : read request and address
//   R0_data, R0_valid  : registered read data (held between reads) and one-cycle valid pulse
//   W0_en, W0_addr     : write request and address
//   W0_data, W0_mask   : write data and per-lane write enables
module sram_1r1w_bypass_ext #(
    parameter int DEPTH     = 512,
    parameter int WIDTH     = 64,
    parameter int MASK_GRAN = 16,
    parameter int LATENCY   = 1,
    parameter int BYPASS    = 1,
    localparam int AW = $clog2(DEPTH) < 1 ? 1 : $clog2(DEPTH),
    localparam int NL = WIDTH / MASK_GRAN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             R0_en,
    input  logic [AW-1:0]    R0_addr,
    output logic [WIDTH-1:0] R0_data,
    output logic             R0_valid,
    input  logic             W0_en,
    input  logic [AW-1:0]    W0_addr,
    input  logic [WIDTH-1:0] W0_data,
    input  logic [NL-1:0]    W0_mask
);
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [LATENCY-1:0] vld;
    logic [WIDTH-1:0]   dat [LATENCY];
    logic [WIDTH-1:0]   rd_word;
    logic               rd_in, wr_in, hit;

    assign rd_in = 32'(R0_addr) < DEPTH;
    assign wr_in = 32'(W0_addr) < DEPTH;
    assign hit   = BYPASS != 0 && R0_en && W0_en && rd_in && wr_in && R0_addr == W0_addr;

    // Old contents, with written lanes forwarded when write-first bypass applies.
    always_comb begin
        rd_word = rd_in ? mem[R0_addr] : '0;
        for (int i = 0; i < NL; i++)
            rd_word[i*MASK_GRAN +: MASK_GRAN] = hit && W0_mask[i] ? W0_data[i*MASK_GRAN +: MASK_GRAN]
                                                                  : rd_word[i*MASK_GRAN +: MASK_GRAN];
    end

    always_ff @(posedge clock)
        if (!reset && W0_en && wr_in)
            for (int i = 0; i < NL; i++)
                if (W0_mask[i])
                    mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];

    // Capture stage, optional extra stage, then the held output register.
    always_ff @(posedge clock) begin
        for (int i = LATENCY - 1; i > 0; i--) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
        end
        vld[0] <= R0_en;
        dat[0] <= rd_word;
        R0_valid <= vld[LATENCY-1];
        if (vld[LATENCY-1])
            R0_data <= dat[LATENCY-1];
        if (reset) begin
            vld      <= '0;
            R0_valid <= 1'b0;
            R0_data  <= '0;
        end
    end
endmodule

// File: tb/tb_sram_1r1w_bypass_ext.sv
// tb_sram_1r1w_bypass_ext: scoreboard bench over four configurations driven by one shared stimulus stream
module tb_sram_1r1w_bypass_ext;
    localparam int N = 4;

    typedef struct {
        logic [63:0] d;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        r_en = 1'b0;
    logic [8:0]  r_addr = '0;
    logic        w_en = 1'b0;
    logic [8:0]  w_addr = '0;
    logic [63:0] w_data = '0;
    logic [3:0]  w_mask = '0;
    logic [63:0] r_data [N];
    logic [N-1:0] r_valid;

    int lat [N] = '{1, 1, 2, 1};
    int byp [N] = '{1, 0, 1, 1};
    int dep [N] = '{512, 512, 512, 300};

    exp_t        q [N][$];
    logic [63:0] ref_mem [512];
    logic [63:0] last [N] = '{default: '0};
    int          cycle = 0;
    logic        rst_q = 1'b1;
    logic        mon_on = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    sram_1r1w_bypass_ext u0 (.clock(clock), .reset(reset), .R0_en(r_en), .R0_addr(r_addr), .R0_data(r_data[0]),
        .R0_valid(r_valid[0]), .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask));
    sram_1r1w_bypass_ext #(.BYPASS(0)) u1 (.clock(clock), .reset(reset), .R0_en(r_en), .R0_addr(r_addr),
        .R0_data(r_data[1]), .R0_valid(r_valid[1]), .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask));
    sram_1r1w_bypass_ext #(.LATENCY(2)) u2 (.clock(clock), .reset(reset), .R0_en(r_en), .R0_addr(r_addr),
        .R0_data(r_data[2]), .R0_valid(r_valid[2]), .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask));
    sram_1r1w_bypass_ext #(.DEPTH(300)) u3 (.clock(clock), .reset(reset), .R0_en(r_en), .R0_addr(r_addr),
        .R0_data(r_data[3]), .R0_valid(r_valid[3]), .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask));

    always @(posedge clock) begin
        cycle <= cycle + 1;
        rst_q <= reset;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [3:0] m);
        logic [63:0] r = old;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[i*16 +: 16] = nw[i*16 +: 16];
        return r;
    endfunction

    // One clock edge of stimulus; expectations are queued at drive time.
    task automatic step(input logic rst, input logic re, input int ra, input logic we, input int wa,
                        input logic [63:0] wd, input logic [3:0] wm);
        logic [63:0] e;
        reset = rst; r_en = re; r_addr = 9'(ra); w_en = we; w_addr = 9'(wa); w_data = wd; w_mask = wm;
        if (rst) begin
            for (int k = 0; k < N; k++)
                while (q[k].size() > 0 && q[k][$].due > cycle) void'(q[k].pop_back());
        end else begin
            if (re)
                for (int k = 0; k < N; k++) begin
                    e = ra >= dep[k] ? 64'h0 : ref_mem[ra];
                    if (ra < dep[k] && byp[k] != 0 && we && wa == ra) e = merge(e, wd, wm);
                    q[k].push_back('{e, cycle + 1 + lat[k]});
                end
            if (we) ref_mem[wa] = merge(ref_mem[wa], wd, wm);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 64'h0, 4'h0);
    endtask

    always @(negedge clock)
        if (mon_on)
            for (int k = 0; k < N; k++) begin
                if (rst_q) begin
                    chk($sformatf("u%0d_rst_valid", k), 64'(r_valid[k]), 64'h0);
                    chk($sformatf("u%0d_rst_data", k), r_data[k], 64'h0);
                    last[k] = '0;
                end else begin
                    logic pend;
                    exp_t e;
                    pend = q[k].size() > 0 && q[k][0].due == cycle;
                    chk($sformatf("u%0d_valid@%0d", k, cycle), 64'(r_valid[k]), 64'(pend));
                    if (pend) begin
                        e = q[k].pop_front();
                        chk($sformatf("u%0d_data@%0d", k, cycle), r_data[k], e.d);
                        last[k] = e.d;
                    end else
                        chk($sformatf("u%0d_hold@%0d", k, cycle), r_data[k], last[k]);
                end
            end

    initial begin
        step(1, 0, 0, 0, 0, 64'h0, 4'h0);
        mon_on = 1'b1;
        step(1, 0, 0, 0, 0, 64'h0, 4'h0);
        // masked write
        step(0, 0, 0, 1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF);
        step(0, 0, 0, 1, 5, 64'h1111_2222_3333_4444, 4'h5);
        step(0, 1, 5, 0, 0, 64'h0, 4'h0);
        idle(2);
        // same-address collision
        step(0, 0, 0, 1, 9, 64'hAAAA_AAAA_AAAA_AAAA, 4'hF);
        step(0, 1, 9, 1, 9, 64'h5555_5555_5555_5555, 4'h3);
        idle(2);
        step(0, 1, 9, 0, 0, 64'h0, 4'h0);
        // hold against later writes
        step(0, 0, 0, 1, 3, 64'h1234, 4'hF);
        step(0, 1, 3, 0, 0, 64'h0, 4'h0);
        step(0, 0, 0, 1, 3, 64'hBEEF, 4'hF);
        idle(4);
        // streaming reads
        step(0, 0, 0, 1, 0, 64'h10, 4'hF);
        step(0, 0, 0, 1, 1, 64'h11, 4'hF);
        step(0, 0, 0, 1, 2, 64'h12, 4'hF);
        step(0, 1, 0, 0, 0, 64'h0, 4'h0);
        step(0, 1, 1, 0, 0, 64'h0, 4'h0);
        step(0, 1, 2, 0, 0, 64'h0, 4'h0);
        idle(3);
        // reset with a read in flight; requests during reset must be ignored
        step(0, 1, 2, 0, 0, 64'h0, 4'h0);
        step(1, 1, 2, 1, 2, 64'hDEAD_DEAD_DEAD_DEAD, 4'hF);
        idle(3);
        step(0, 1, 2, 0, 0, 64'h0, 4'h0);
        idle(3);
        // write then read on the following edge
        step(0, 0, 0, 1, 7, 64'h42, 4'hF);
        step(0, 1, 7, 0, 0, 64'h0, 4'h0);
        // out-of-range on the 300-entry instance
        step(0, 0, 0, 1, 310, 64'h99, 4'hF);
        step(0, 1, 310, 0, 0, 64'h0, 4'h0);
        step(0, 0, 0, 1, 299, 64'h77, 4'hF);
        step(0, 1, 299, 0, 0, 64'h0, 4'h0);
        idle(5);
        for (int k = 0; k < N; k++) chk($sformatf("u%0d_drained", k), 64'(q[k].size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
